// File: rtl/spu_boot_loader_pkg.sv
// spu_boot_loader_pkg: record encodings, FSM states and header field positions for the boot loader
package spu_boot_loader_pkg;

    localparam logic [3:0] REC_INSTR = 4'd1;
    localparam logic [3:0] REC_REG   = 4'd2;
    localparam logic [3:0] REC_LS    = 4'd3;
    localparam logic [3:0] REC_DONE  = 4'd15;

    typedef enum logic [2:0] {S_HDR, S_INSTR, S_REG, S_LS, S_DONE, S_ERR} state_t;

    // Header word fields, in the stream's MSB-first bit numbering.
    localparam int HDR_TYPE_FIRST = 0;
    localparam int HDR_TYPE_LAST  = 3;
    localparam int HDR_ADDR_FIRST = 4;
    localparam int HDR_ADDR_LAST  = 18;
    localparam int HDR_CNT_FIRST  = 19;
    localparam int HDR_CNT_LAST   = 31;

endpackage

// File: rtl/spu_boot_loader_qword_assembler.sv
// qword_assembler: gathers four stream words into one quadword, first word in the top bits
module qword_assembler (
    input  logic          clk,
    input  logic          rst,
    input  logic          word_valid,
    input  logic [0:31]   word,
    output logic [0:127]  qword,
    output logic          qword_valid
);

    logic [0:95] buf_q;
    logic [1:0]  idx;

    // The fourth word is merged combinationally so the caller can register it in the same edge.
    assign qword       = {buf_q, word};
    assign qword_valid = word_valid && idx == 2'd3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q <= '0;
            idx   <= '0;
        end else if (word_valid) begin
            buf_q <= {buf_q[32:95], word};
            idx   <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/spu_boot_loader.sv
// spu_boot_loader: parses header/payload records from a word stream and preloads the SPU core,
// holding it in reset until a DONE record arrives.
module spu_boot_loader
    import spu_boot_loader_pkg::*;
#(
    parameter int CNT_W  = 13,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [0:WORD_W-1] s_data,
    output logic              load_en,
    output logic [0:31]       instruction_in,
    output logic [0:9]        instr_load_addr,
    output logic              preload_en,
    output logic [0:9]        preload_addr,
    output logic [0:127]      preload_values,
    output logic              preload_LS_en,
    output logic [0:14]       preload_LS_addr,
    output logic [0:127]      preload_LS_data,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    state_t           state;
    logic [14:0]      addr;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       f_type;
    logic [14:0]      f_addr;
    logic [CNT_W-1:0] f_cnt;
    logic             accept;
    logic [0:127]     qword;
    logic             qword_valid;

    assign f_type = s_data[HDR_TYPE_FIRST:HDR_TYPE_LAST];
    assign f_addr = s_data[HDR_ADDR_FIRST:HDR_ADDR_LAST];
    assign f_cnt  = s_data[HDR_CNT_FIRST:HDR_CNT_LAST];
    assign accept = s_valid && s_ready;

    qword_assembler u_qword_assembler (
        .clk        (clk),
        .rst        (rst),
        .word_valid (accept && (state == S_REG || state == S_LS)),
        .word       (s_data),
        .qword      (qword),
        .qword_valid(qword_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_HDR;
            addr            <= '0;
            cnt             <= '0;
            s_ready         <= 1'b0;
            load_en         <= 1'b0;
            instruction_in  <= '0;
            instr_load_addr <= '0;
            preload_en      <= 1'b0;
            preload_addr    <= '0;
            preload_values  <= '0;
            preload_LS_en   <= 1'b0;
            preload_LS_addr <= '0;
            preload_LS_data <= '0;
            core_rst        <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            load_en       <= 1'b0;
            preload_en    <= 1'b0;
            preload_LS_en <= 1'b0;
            // Terminal transitions below override this so ready drops the cycle after the header.
            s_ready       <= state inside {S_HDR, S_INSTR, S_REG, S_LS};
            case (state)
                S_HDR: if (accept) begin
                    cnt  <= f_cnt;
                    addr <= f_type == REC_LS ? {f_addr[14:4], 4'h0} : {5'h0, f_addr[9:0]};
                    if (f_type == REC_DONE) begin
                        state    <= S_DONE;
                        s_ready  <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b1;
                    end else if (f_type inside {REC_INSTR, REC_REG, REC_LS}) begin
                        if (f_cnt != '0)
                            state <= f_type == REC_INSTR ? S_INSTR : f_type == REC_REG ? S_REG : S_LS;
                    end else begin
                        state   <= S_ERR;
                        s_ready <= 1'b0;
                        error   <= 1'b1;
                    end
                end
                S_INSTR: if (accept) begin
                    load_en         <= 1'b1;
                    instruction_in  <= s_data;
                    instr_load_addr <= addr[9:0];
                    addr            <= {5'h0, addr[9:0] + 10'd1};
                    cnt             <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= S_HDR;
                end
                S_REG, S_LS: if (qword_valid) begin
                    if (state == S_REG) begin
                        preload_en     <= 1'b1;
                        preload_addr   <= addr[9:0];
                        preload_values <= qword;
                        addr           <= {5'h0, addr[9:0] + 10'd1};
                    end else begin
                        preload_LS_en   <= 1'b1;
                        preload_LS_addr <= addr;
                        preload_LS_data <= qword;
                        addr            <= addr + 15'd16;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= S_HDR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spu_boot_loader.md
# spu_boot_loader

Program/preload sequencer that sits directly upstream of the SPU core top level. It consumes a 32-bit word stream over a valid/ready handshake and drives the core's instruction-memory load port, register-file preload port and local-store preload port. When a DONE record arrives it releases the core from reset. Until then the core is held in reset while memories are filled.

## Interface
Parameters:
- `CNT_W`, 13: width of the record count field.
- `WORD_W`, 32: stream word width. Fixed at 32; the parameter is not to be overridden.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-low.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader accepts a word. A transfer occurs when `s_valid` and `s_ready` are both high.
- `s_data`  in  32 [0:31]  stream word. Bit 0 is the MSB.
- `load_en`  out  1  instruction write strobe to core.
- `instruction_in`  out  32 [0:31]  instruction word.
- `instr_load_addr`  out  10 [0:9]  instruction word address.
- `preload_en`  out  1  register write strobe.
- `preload_addr`  out  10 [0:9]  register index.
- `preload_values`  out  128 [0:127]  register value.
- `preload_LS_en`  out  1  local-store write strobe.
- `preload_LS_addr`  out  15 [0:14]  local-store byte address, quadword-aligned.
- `preload_LS_data`  out  128 [0:127]  quadword data.
- `core_rst`  out  1  active-low reset to core. Held low until DONE.
- `done`  out  1  load sequence complete.
- `error`  out  1  illegal header received.

## Operation
Each record is one header word followed by a payload.

Header layout:
- `[0:3]` type: 1 = INSTR, 2 = REG, 3 = LS, 15 = DONE. Any other value is illegal.
- `[4:18]` start address, 15 bits.
- `[19:31]` count.

Address use by type:
- INSTR uses address bits `[9:18]`.
- REG uses address bits `[9:18]`.
- LS uses all 15 address bits; the low 4 bits are forced to 0.

Payload:
- INSTR: `count` words, one instruction each.
- REG and LS: `count` quadwords, 4 words each. The first word maps to bits `[0:31]`, the fourth to `[96:127]`.
- `count` = 0 means no payload; the FSM returns to HDR.

FSM states: HDR, INSTR, REG, LS, DONE, ERR.
- HDR accepts a header:
  - type 1 → INSTR, type 2 → REG, type 3 → LS (each loads the address and remaining count).
  - type 15 → DONE.
  - illegal type → ERR.
- INSTR: each accepted word pulses `load_en` with the current address, then increments the address by 1, wrapping mod 1024. The count decrements; when it reaches 0 the FSM goes to HDR.
- REG and LS: a 2-bit word index assembles the quadword. On the 4th word the FSM pulses `preload_en` or `preload_LS_en`. The REG address then increments by 1 (mod 1024); the LS address increments by 16 (mod 32768). The count decrements; when it reaches 0 the FSM goes to HDR.
- DONE: `done` = 1, `core_rst` = 1, `s_ready` = 0. Terminal until `rst`.
- ERR: `error` = 1, `s_ready` = 0, `core_rst` stays 0. Terminal until `rst`.
- Only one strobe output is high in any cycle.

## Timing
- `s_ready` = 1 in HDR, INSTR, REG and LS; 0 in DONE, ERR and during reset. It is never combinationally dependent on `s_valid`.
- Strobe latency: a word accepted on edge N produces its strobe and data/address outputs valid in cycle N+1, all registered. Strobes are single-cycle pulses.
- Data and address outputs hold their last value between strobes.
- `done` and `core_rst` rise in the cycle after the DONE header is accepted. `error` rises in the cycle after the illegal header is accepted.
- Throughput: one word per cycle. There are no bubbles between records, so a header can be accepted in the cycle after the last payload word.
- Reset values:
  - All strobes 0; all data/address outputs 0.
  - `s_ready` 0; `core_rst` 0; `done` 0; `error` 0.
  - FSM in HDR; `s_ready` goes to 1 in the first cycle after `rst` deasserts.
- Reset during a record: the partial quadword and the remaining count are discarded, and no strobe is issued for the partial data.
- Wrap: an address at its maximum (1023, or LS 0x7FF0) wraps to 0 after the write. The write at the maximum address itself is performed.

## Structure
- A shared package holds:
  - the record type encodings (`REC_INSTR` = 1, `REC_REG` = 2, `REC_LS` = 3, `REC_DONE` = 15);
  - the FSM state enum;
  - the header field bit positions.
- One sub-module, `qword_assembler`: a 4-word shift/merge with an index counter and a `qword_valid` pulse. It is shared by the REG and LS paths.

## Test plan
- INSTR record: header `0x1` + addr 0x005 + count 2, then words 0xAAAA0001 and 0xAAAA0002 → `load_en` pulses at addr 5 with 0xAAAA0001, then at addr 6 with 0xAAAA0002. `core_rst` stays 0.
- REG record: addr 3, count 1, words 0x11111111 / 0x22222222 / 0x33333333 / 0x44444444 → one `preload_en` pulse, `preload_addr` = 3, `preload_values` = 0x11111111_22222222_33333333_44444444.
- LS wrap: addr 0x7FF0, count 2, 8 words → `preload_LS_en` at 0x7FF0, then at 0x0000.
- DONE header → next cycle `done` = 1 and `core_rst` = 1. `s_ready` = 0; further `s_valid` is ignored.
- Illegal type 7 → `error` = 1, `s_ready` = 0, `core_rst` = 0. Then pulse `rst` low mid-REG record after 2 words → no `preload_en`, and the next header is accepted cleanly.
- Back-to-back traffic with `s_valid` held high across two records → one word accepted per cycle, and strobes match the expected sequence exactly.
